// File: rtl/common_pkg.sv
// Shared types and constants for the post-run register dump path.
// Holds the dump FSM state encoding and the default stream sync byte.
package common_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LATCH,
    SEND,
    FINISH
  } dump_state_t;

  localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register file after a test run and streams every register
// out little-endian on a valid/ready byte stream, optionally behind a sync byte.
module reg_dump_reader
  import common_pkg::*;
#(
  parameter int         NUM_REGS    = 32,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BYTE = DUMP_HEADER_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  reg_read_id,
  input  logic [31:0] reg_read_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_ID = 5'(NUM_REGS - 1);

  if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_badNumRegs
    $error("reg_dump_reader: NUM_REGS must be in 1..32");
  end

  dump_state_t r_state;
  dump_state_t w_nextState;
  logic [4:0]  r_index;
  logic [31:0] r_shift;
  logic [1:0]  r_byteCnt;
  logic        w_lastByte;

  assign reg_read_id = r_index;
  assign w_lastByte  = (r_byteCnt == 2'd3);

  // Outputs decode from state only, so out_valid never depends on out_ready.
  always_comb begin
    w_nextState = r_state;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = HEADER_EN ? HEADER : LATCH;
      end
      HEADER: begin
        out_valid = 1'b1;
        out_data  = HEADER_BYTE;
        busy      = 1'b1;
        if (out_ready) w_nextState = LATCH;
      end
      LATCH: begin
        busy        = 1'b1;
        w_nextState = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = r_shift[7:0];
        busy      = 1'b1;
        if (out_ready && w_lastByte)
          w_nextState = (r_index == LAST_ID) ? FINISH : LATCH;
      end
      FINISH: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_index   <= 5'd0;
      r_shift   <= 32'd0;
      r_byteCnt <= 2'd0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: r_index <= 5'd0;
        LATCH: begin
          r_shift   <= reg_read_data;
          r_byteCnt <= 2'd0;
        end
        SEND: begin
          if (out_ready) begin
            r_shift   <= r_shift >> 8;
            r_byteCnt <= r_byteCnt + 2'd1;
            // Index holds on the final register so reg_read_id stays put until IDLE.
            if (w_lastByte && r_index != LAST_ID) r_index <= r_index + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: cycle vector table plus
// scoreboarded full dumps (backpressure, start re-pulse, mid-dump reset, no header).
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, ready1, valid1, busy1, done1;
  logic        start2, ready2, valid2, busy2, done2;
  logic [4:0]  id1, id2;
  logic [31:0] rdata1, rdata2;
  logic [7:0]  data1, data2;

  always #5 clk = ~clk;

  function automatic logic [31:0] regModel(input logic [4:0] id);
    case (id)
      5'd0:    return 32'h0000_0000;
      5'd1:    return 32'h1234_5678;
      5'd31:   return 32'hDEAD_BEEF;
      default: return {27'd0, id};
    endcase
  endfunction

  assign rdata1 = regModel(id1);
  assign rdata2 = regModel(id2);

  reg_dump_reader #(.NUM_REGS(32), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .reg_read_id(id1), .reg_read_data(rdata1),
    .out_valid(valid1), .out_data(data1), .out_ready(ready1), .busy(busy1), .done(done1)
  );

  reg_dump_reader #(.NUM_REGS(4), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .reg_read_id(id2), .reg_read_data(rdata2),
    .out_valid(valid2), .out_data(data2), .out_ready(ready2), .busy(busy2), .done(done2)
  );

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  bit         sbEn1 = 1'b0, sbEn2 = 1'b0;
  bit         stall1 = 1'b0, stall2 = 1'b0;
  logic [7:0] prevData1, prevData2;
  int         acc1 = 0, acc2 = 0, doneCnt1 = 0, doneCnt2 = 0;

  // Bytes are scored when valid & ready are seen, i.e. the handshake at the next rising edge.
  always @(negedge clk) begin
    if (done1) doneCnt1++;
    if (sbEn1 && !rst) begin
      if (stall1) begin
        checkOutput("stable_valid1", {31'd0, valid1}, 32'd1);
        checkOutput("stable_data1", {24'd0, data1}, {24'd0, prevData1});
      end
      if (valid1 && ready1) begin
        acc1++;
        if (q1.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL extra_byte1: got %0h expected no byte", data1);
        end else checkOutput($sformatf("dut1_byte%0d", acc1 - 1), {24'd0, data1}, {24'd0, q1.pop_front()});
      end
      stall1    = valid1 && !ready1;
      prevData1 = data1;
    end else stall1 = 1'b0;
  end

  always @(negedge clk) begin
    if (done2) doneCnt2++;
    if (sbEn2 && !rst) begin
      if (stall2) begin
        checkOutput("stable_valid2", {31'd0, valid2}, 32'd1);
        checkOutput("stable_data2", {24'd0, data2}, {24'd0, prevData2});
      end
      if (valid2 && ready2) begin
        acc2++;
        if (q2.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL extra_byte2: got %0h expected no byte", data2);
        end else checkOutput($sformatf("dut2_byte%0d", acc2 - 1), {24'd0, data2}, {24'd0, q2.pop_front()});
      end
      stall2    = valid2 && !ready2;
      prevData2 = data2;
    end else stall2 = 1'b0;
  end

  task automatic pushExpected(input bit toDut2, input int nRegs, input bit hdr);
    logic [31:0] v;
    if (hdr) begin
      if (toDut2) q2.push_back(8'hA5); else q1.push_back(8'hA5);
    end
    for (int r = 0; r < nRegs; r++) begin
      v = regModel(5'(r));
      for (int k = 0; k < 4; k++) begin
        if (toDut2) q2.push_back(v[8*k +: 8]); else q1.push_back(v[8*k +: 8]);
      end
    end
  endtask

  task automatic applyStimulus(input bit useDut2, input bit st, input bit rdy);
    if (useDut2) begin start2 = st; ready2 = rdy; end
    else begin start1 = st; ready1 = rdy; end
  endtask

  // One complete dump; expCycles = 0 skips the start-to-done latency check.
  task automatic runDump(input bit useDut2, input int expCycles, input int expBytes,
                         input bit randReady, input bit repulse);
    int  cyc;
    bit  finished;
    if (useDut2) begin
      q2.delete(); acc2 = 0; doneCnt2 = 0; sbEn2 = 1'b1;
      pushExpected(1'b1, 4, 1'b0);
    end else begin
      q1.delete(); acc1 = 0; doneCnt1 = 0; sbEn1 = 1'b1;
      pushExpected(1'b0, 32, 1'b1);
    end
    @(posedge clk); #1;
    applyStimulus(useDut2, 1'b1, randReady ? 1'($urandom_range(0, 1)) : 1'b1);
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      applyStimulus(useDut2, repulse && (cyc == 10 || cyc == 100),
                    randReady ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (useDut2 ? done2 : done1) finished = 1'b1;
    end
    if (!finished) begin
      total++; bad++;
      $display("[TB] FAIL dump_timeout: got no done expected done within 3000 cycles");
    end else if (expCycles > 0) checkOutput("done_latency", cyc, expCycles);
    @(posedge clk); #1;
    applyStimulus(useDut2, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("byte_count", useDut2 ? acc2 : acc1, expBytes);
    checkOutput("bytes_left", useDut2 ? q2.size() : q1.size(), 0);
    checkOutput("done_pulses", useDut2 ? doneCnt2 : doneCnt1, 1);
    checkOutput("busy_after", {31'd0, useDut2 ? busy2 : busy1}, 32'd0);
  endtask

  typedef struct {
    bit         rstIn;
    bit         startIn;
    bit         readyIn;
    bit         expValid;
    bit         expBusy;
    bit         expDone;
    logic [4:0] expId;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 5'd0, 8'h00};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 5'd0, 8'h00};
    vecs[2]  = '{0, 1, 0, 1, 1, 0, 5'd0, 8'hA5};
    vecs[3]  = '{0, 0, 0, 1, 1, 0, 5'd0, 8'hA5};
    vecs[4]  = '{0, 0, 1, 0, 1, 0, 5'd0, 8'h00};
    vecs[5]  = '{0, 0, 1, 1, 1, 0, 5'd0, 8'h00};
    vecs[6]  = '{0, 0, 1, 1, 1, 0, 5'd0, 8'h00};
    vecs[7]  = '{0, 0, 1, 1, 1, 0, 5'd0, 8'h00};
    vecs[8]  = '{0, 0, 1, 1, 1, 0, 5'd0, 8'h00};
    vecs[9]  = '{0, 0, 1, 0, 1, 0, 5'd1, 8'h00};
    vecs[10] = '{0, 0, 1, 1, 1, 0, 5'd1, 8'h78};
    vecs[11] = '{0, 0, 0, 1, 1, 0, 5'd1, 8'h78};
    vecs[12] = '{0, 0, 1, 1, 1, 0, 5'd1, 8'h56};
    vecs[13] = '{1, 0, 1, 0, 0, 0, 5'd0, 8'h00};

    rst = 1'b1;
    start1 = 1'b0; ready1 = 1'b0;
    start2 = 1'b0; ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset with no start request.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_valid1", {31'd0, valid1}, 32'd0);
      checkOutput("idle_busy1", {31'd0, busy1}, 32'd0);
      checkOutput("idle_done1", {31'd0, done1}, 32'd0);
      checkOutput("idle_id1", {27'd0, id1}, 32'd0);
      checkOutput("idle_busy2", {31'd0, busy2}, 32'd0);
    end

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rstIn;
      applyStimulus(1'b0, vecs[i].startIn, vecs[i].readyIn);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, valid1}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy1}, {31'd0, vecs[i].expBusy});
      checkOutput($sformatf("vec%0d_done", i), {31'd0, done1}, {31'd0, vecs[i].expDone});
      checkOutput($sformatf("vec%0d_id", i), {27'd0, id1}, {27'd0, vecs[i].expId});
      checkOutput($sformatf("vec%0d_data", i), {24'd0, data1}, {24'd0, vecs[i].expData});
      #1;
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] full dump, ready held high");
    runDump(1'b0, 162, 129, 1'b0, 1'b0);
    $display("[TB] full dump, random backpressure");
    runDump(1'b0, 0, 129, 1'b1, 1'b0);
    $display("[TB] full dump, start re-pulsed while busy");
    runDump(1'b0, 162, 129, 1'b0, 1'b1);

    // Reset after the 40th accepted byte, then a fresh dump.
    $display("[TB] reset mid-dump");
    q1.delete(); acc1 = 0; sbEn1 = 1'b1;
    pushExpected(1'b0, 32, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 500 && acc1 < 40; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("acc_before_rst", acc1, 40);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", {31'd0, valid1}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy1}, 32'd0);
    checkOutput("rst_done", {31'd0, done1}, 32'd0);
    checkOutput("rst_id", {27'd0, id1}, 32'd0);
    checkOutput("rst_data", {24'd0, data1}, 32'd0);
    checkOutput("acc_after_rst", acc1, 40);
    runDump(1'b0, 162, 129, 1'b0, 1'b0);

    $display("[TB] no header, four registers");
    runDump(1'b1, 21, 16, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
